// File: rtl/branch_resolve_pkg.sv
// Shared types for the EX-stage branch resolver: condition codes, FSM states
// and the JALR target helper.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    BC_BEQ  = 3'b000,
    BC_BNE  = 3'b001,
    BC_BLT  = 3'b100,
    BC_BGE  = 3'b101,
    BC_BLTU = 3'b110,
    BC_BGEU = 3'b111
  } branch_cond_e;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_e;

  // Flush counter width; covers FLUSH_CYCLES up to 7.
  localparam int FLUSH_CNT_W = 3;

  // JALR target: base + offset with bit 0 forced low.
  function automatic logic [31:0] jalr_target(input logic [31:0] base,
                                              input logic [31:0] ofs);
    logic [31:0] sum;
    sum = base + ofs;
    return {sum[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage bundle between the pipeline and the branch resolver. The master
// side drives the instruction and ALU flags, the slave side returns the
// redirect, flush, misalignment report and performance counters.
interface branch_resolve_if #(
  parameter int CNT_WIDTH = 32
);

  logic                 valid_i;
  logic                 stall_i;
  logic                 is_branch_i;
  logic                 is_jal_i;
  logic                 is_jalr_i;
  logic [2:0]           funct3_i;
  logic [31:0]          pc_i;
  logic [31:0]          imm_i;
  logic [31:0]          rs1_i;
  logic                 Z_i;
  logic                 N_i;
  logic                 S_i;
  logic                 C_i;
  logic                 V_i;

  logic                 redirect_o;
  logic [31:0]          redirect_pc_o;
  logic                 flush_o;
  logic                 misaligned_o;
  logic [31:0]          bad_pc_o;
  logic [CNT_WIDTH-1:0] branch_cnt_o;
  logic [CNT_WIDTH-1:0] taken_cnt_o;

  modport master (
    output valid_i, stall_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
           pc_i, imm_i, rs1_i, Z_i, N_i, S_i, C_i, V_i,
    input  redirect_o, redirect_pc_o, flush_o, misaligned_o, bad_pc_o,
           branch_cnt_o, taken_cnt_o
  );

  modport slave (
    input  valid_i, stall_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
           pc_i, imm_i, rs1_i, Z_i, N_i, S_i, C_i, V_i,
    output redirect_o, redirect_pc_o, flush_o, misaligned_o, bad_pc_o,
           branch_cnt_o, taken_cnt_o
  );

endinterface

// File: rtl/branch_resolve_cond.sv
// Branch condition evaluator. Purely combinational: takes funct3 and the
// flags of the ALU SUB rs1-rs2 (c = borrow, s = n ^ v) and says whether the
// conditional branch is taken. Unknown codes are never taken.
module branch_resolve_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       s,
  input  logic       c,
  output logic       cond
);

  // Map each condition code onto the relevant SUB flag
  always_comb begin
    cond = 1'b0;
    case (funct3)
      BC_BEQ:  cond = z;
      BC_BNE:  cond = ~z;
      BC_BLT:  cond = s;
      BC_BGE:  cond = ~s;
      BC_BLTU: cond = c;
      BC_BGEU: cond = ~c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver. Evaluates the branch condition, computes the
// branch/JAL/JALR target, issues a registered redirect one cycle after
// accept, then holds flush_o for FLUSH_CYCLES unstalled cycles while the
// wrong-path IF/ID slots drain. Taken targets with bit 1 set are reported
// as misaligned instead of redirected. FLUSH_CYCLES must be 1..7.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  branch_resolve_if.slave bus
);

  br_state_e               state;
  br_state_e               state_next;
  logic [FLUSH_CNT_W-1:0]  cnt;
  logic [FLUSH_CNT_W-1:0]  cnt_next;
  logic                    flush;

  logic                    cond;
  logic                    accept;
  logic                    taken;
  logic [31:0]             target;
  logic                    redirect_now;
  logic                    misalign_now;

  logic                    redirect_p1;
  logic [31:0]             redirect_pc_p1;
  logic                    misaligned_p1;
  logic [31:0]             bad_pc_p1;
  logic [CNT_WIDTH-1:0]    branch_cnt_p1;
  logic [CNT_WIDTH-1:0]    taken_cnt_p1;

  // N and V only matter through S, which the ALU already provides.
  logic                    unused_nv;
  assign unused_nv = bus.N_i ^ bus.V_i;

  branch_resolve_cond u_cond (
    .funct3 (bus.funct3_i),
    .z      (bus.Z_i),
    .s      (bus.S_i),
    .c      (bus.C_i),
    .cond   (cond)
  );

  // Instructions arriving while flushing are wrong-path and never accepted.
  assign accept = bus.valid_i & ~bus.stall_i & (state == BR_IDLE);

  // Any jump bit beats the branch bit; JALR beats JAL for the target.
  assign taken  = bus.is_jal_i | bus.is_jalr_i | (bus.is_branch_i & cond);
  assign target = bus.is_jalr_i ? jalr_target(bus.rs1_i, bus.imm_i)
                                : bus.pc_i + bus.imm_i;

  assign redirect_now = accept & taken & ~target[1];
  assign misalign_now = accept & taken &  target[1];

  // FSM state and flush counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= BR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: enter FLUSH on an aligned taken accept; count down only
  // on unstalled cycles so flush spans FLUSH_CYCLES real fetch slots
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    flush      = 1'b0;
    case (state)
      BR_IDLE: begin
        if (redirect_now) begin
          state_next = BR_FLUSH;
          cnt_next   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      BR_FLUSH: begin
        flush = 1'b1;
        if (!bus.stall_i) begin
          if (cnt == '0) state_next = BR_IDLE;
          else           cnt_next   = cnt - 1'b1;
        end
      end
      default: state_next = BR_IDLE;
    endcase
  end

  // ---- stage p1: registered redirect / misalignment reports ----
  // Pulses last one cycle; the target registers hold between pulses
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      misaligned_p1  <= 1'b0;
      bad_pc_p1      <= '0;
    end else begin
      redirect_p1   <= redirect_now;
      misaligned_p1 <= misalign_now;
      if (redirect_now) redirect_pc_p1 <= target;
      if (misalign_now) bad_pc_p1      <= target;
    end
  end

  // Performance counters; taken includes misaligned jumps, both wrap
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      branch_cnt_p1 <= '0;
      taken_cnt_p1  <= '0;
    end else begin
      if (accept && bus.is_branch_i) branch_cnt_p1 <= branch_cnt_p1 + 1'b1;
      if (accept && taken)           taken_cnt_p1  <= taken_cnt_p1 + 1'b1;
    end
  end

  assign bus.redirect_o    = redirect_p1;
  assign bus.redirect_pc_o = redirect_pc_p1;
  assign bus.flush_o       = flush;
  assign bus.misaligned_o  = misaligned_p1;
  assign bus.bad_pc_o      = bad_pc_p1;
  assign bus.branch_cnt_o  = branch_cnt_p1;
  assign bus.taken_cnt_o   = taken_cnt_p1;

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed scenarios plus a randomized run
// against a reference model that derives conditions from rs1/rs2 values by
// plain signed/unsigned comparison.
module tb_branch_resolve;

  localparam int FC = 2;
  localparam int CW = 32;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  branch_resolve_if #(.CNT_WIDTH(CW)) bus ();

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_branch = '0;
  logic [CW-1:0] exp_taken  = '0;
  logic [31:0]   last_rpc   = '0;
  logic [31:0]   last_bad   = '0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.valid_i = 0; bus.stall_i = 0; bus.is_branch_i = 0; bus.is_jal_i = 0;
    bus.is_jalr_i = 0; bus.funct3_i = '0; bus.pc_i = '0; bus.imm_i = '0;
    bus.rs1_i = '0; bus.Z_i = 0; bus.N_i = 0; bus.S_i = 0; bus.C_i = 0; bus.V_i = 0;
  endtask

  // Present one instruction; flags are what an ALU SUB a-b would produce.
  task automatic drive(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic n, v;
    d = a - b;
    n = d[31];
    v = (a[31] != b[31]) && (d[31] != a[31]);
    bus.valid_i = 1; bus.is_branch_i = br; bus.is_jal_i = jal; bus.is_jalr_i = jalr;
    bus.funct3_i = f3; bus.pc_i = pc; bus.imm_i = imm; bus.rs1_i = rs1;
    bus.Z_i = (d == 0); bus.N_i = n; bus.V_i = v; bus.S_i = n ^ v; bus.C_i = (a < b);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%0h exp=0", bus.redirect_pc_o); end
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%0h exp=0", bus.flush_o); end
    n_checks++; if (bus.misaligned_o !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got=%0h exp=0", bus.misaligned_o); end
    n_checks++; if (bus.bad_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_bad_pc got=%0h exp=0", bus.bad_pc_o); end
    n_checks++; if (bus.branch_cnt_o !== '0) begin n_fail++; $display("FAIL reset_branch_cnt got=%0h exp=0", bus.branch_cnt_o); end
    n_checks++; if (bus.taken_cnt_o !== '0) begin n_fail++; $display("FAIL reset_taken_cnt got=%0h exp=0", bus.taken_cnt_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_beq();
    drive(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 32'h55, 32'h55);
    tick(); idle();
    exp_branch++; exp_taken++; last_rpc = 32'h120;
    n_checks++; if (bus.redirect_o !== 1'b1) begin n_fail++; $display("FAIL beq_redirect got=%0h exp=1", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h120) begin n_fail++; $display("FAIL beq_target got=%0h exp=120", bus.redirect_pc_o); end
    n_checks++; if (bus.flush_o !== 1'b1) begin n_fail++; $display("FAIL beq_flush_t1 got=%0h exp=1", bus.flush_o); end
    n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL beq_branch_cnt got=%0h exp=%0h", bus.branch_cnt_o, exp_branch); end
    n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL beq_taken_cnt got=%0h exp=%0h", bus.taken_cnt_o, exp_taken); end
    tick();
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL beq_redirect_t2 got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.flush_o !== 1'b1) begin n_fail++; $display("FAIL beq_flush_t2 got=%0h exp=1", bus.flush_o); end
    tick();
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL beq_flush_t3 got=%0h exp=0", bus.flush_o); end
  endtask

  task automatic test_cond_mix();
    // BLTU 1 < 2 unsigned: taken
    drive(1, 0, 0, 3'b110, 32'h200, 32'h10, 32'h0, 32'h1, 32'h2);
    tick(); idle();
    exp_branch++; exp_taken++; last_rpc = 32'h210;
    n_checks++; if (bus.redirect_o !== 1'b1) begin n_fail++; $display("FAIL bltu_redirect got=%0h exp=1", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h210) begin n_fail++; $display("FAIL bltu_target got=%0h exp=210", bus.redirect_pc_o); end
    tick(); tick();
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL bltu_flush_end got=%0h exp=0", bus.flush_o); end
    // BGEU with borrow: not taken
    drive(1, 0, 0, 3'b111, 32'h300, 32'h10, 32'h0, 32'h1, 32'h2);
    tick(); idle();
    exp_branch++;
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL bgeu_redirect got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL bgeu_flush got=%0h exp=0", bus.flush_o); end
    // BLT 1 < INT_MIN is false (N=1, V=1, S=0)
    drive(1, 0, 0, 3'b100, 32'h400, 32'h10, 32'h0, 32'h1, 32'h8000_0000);
    tick(); idle();
    exp_branch++;
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL blt_redirect got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== last_rpc) begin n_fail++; $display("FAIL blt_pc_hold got=%0h exp=%0h", bus.redirect_pc_o, last_rpc); end
    n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL mix_branch_cnt got=%0h exp=%0h", bus.branch_cnt_o, exp_branch); end
    n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL mix_taken_cnt got=%0h exp=%0h", bus.taken_cnt_o, exp_taken); end
  endtask

  task automatic test_jumps();
    drive(0, 0, 1, 3'b000, 32'h500, 32'h3, 32'h2001, 32'h0, 32'h7);
    tick(); idle();
    exp_taken++; last_rpc = 32'h2004;
    n_checks++; if (bus.redirect_o !== 1'b1) begin n_fail++; $display("FAIL jalr_redirect got=%0h exp=1", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h2004) begin n_fail++; $display("FAIL jalr_target got=%0h exp=2004", bus.redirect_pc_o); end
    tick(); tick();
    drive(0, 1, 0, 3'b000, 32'h100, 32'h6, 32'h0, 32'h0, 32'h7);
    tick(); idle();
    exp_taken++; last_bad = 32'h106;
    n_checks++; if (bus.misaligned_o !== 1'b1) begin n_fail++; $display("FAIL jal_misaligned got=%0h exp=1", bus.misaligned_o); end
    n_checks++; if (bus.bad_pc_o !== 32'h106) begin n_fail++; $display("FAIL jal_bad_pc got=%0h exp=106", bus.bad_pc_o); end
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL jal_redirect got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL jal_flush got=%0h exp=0", bus.flush_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h2004) begin n_fail++; $display("FAIL jal_pc_hold got=%0h exp=2004", bus.redirect_pc_o); end
    n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL jal_taken_cnt got=%0h exp=%0h", bus.taken_cnt_o, exp_taken); end
    tick();
    n_checks++; if (bus.misaligned_o !== 1'b0) begin n_fail++; $display("FAIL jal_mis_pulse got=%0h exp=0", bus.misaligned_o); end
    n_checks++; if (bus.bad_pc_o !== 32'h106) begin n_fail++; $display("FAIL jal_bad_hold got=%0h exp=106", bus.bad_pc_o); end
  endtask

  task automatic test_stall_flush();
    drive(1, 0, 0, 3'b001, 32'h600, 32'h40, 32'h0, 32'h3, 32'h4);
    tick(); idle();
    exp_branch++; exp_taken++; last_rpc = 32'h640;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      n_checks++; if (bus.flush_o !== (cyc <= 5)) begin n_fail++; $display("FAIL stall_flush_c%0d got=%0h exp=%0h", cyc, bus.flush_o, (cyc <= 5)); end
      n_checks++; if (bus.redirect_o !== (cyc == 1)) begin n_fail++; $display("FAIL stall_redirect_c%0d got=%0h exp=%0h", cyc, bus.redirect_o, (cyc == 1)); end
      idle();
      case (cyc)
        1, 3: bus.stall_i = 1;
        2: begin drive(1, 0, 0, 3'b000, 32'h700, 32'h8, 32'h0, 32'h9, 32'h9); bus.stall_i = 1; end
        4: drive(0, 1, 0, 3'b000, 32'h800, 32'h10, 32'h0, 32'h0, 32'h0);
        default: ;
      endcase
      tick();
    end
    idle();
    n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL stall_branch_cnt got=%0h exp=%0h", bus.branch_cnt_o, exp_branch); end
    n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL stall_taken_cnt got=%0h exp=%0h", bus.taken_cnt_o, exp_taken); end
    n_checks++; if (bus.redirect_pc_o !== last_rpc) begin n_fail++; $display("FAIL stall_pc_hold got=%0h exp=%0h", bus.redirect_pc_o, last_rpc); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 3'b000, 32'h900, 32'h20, 32'h0, 32'h1, 32'h1);
    tick(); idle();
    #2 reset_i = 1'b1;
    #1;
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL areset_flush got=%0h exp=0", bus.flush_o); end
    n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL areset_redirect got=%0h exp=0", bus.redirect_o); end
    n_checks++; if (bus.branch_cnt_o !== '0) begin n_fail++; $display("FAIL areset_branch_cnt got=%0h exp=0", bus.branch_cnt_o); end
    n_checks++; if (bus.taken_cnt_o !== '0) begin n_fail++; $display("FAIL areset_taken_cnt got=%0h exp=0", bus.taken_cnt_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL areset_pc got=%0h exp=0", bus.redirect_pc_o); end
    reset_i = 1'b0;
    exp_branch = '0; exp_taken = '0; last_rpc = '0; last_bad = '0;
    drive(1, 0, 0, 3'b000, 32'h300, 32'h40, 32'h0, 32'h2, 32'h2);
    tick(); idle();
    exp_branch++; exp_taken++; last_rpc = 32'h340;
    n_checks++; if (bus.redirect_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_redirect got=%0h exp=1", bus.redirect_o); end
    n_checks++; if (bus.redirect_pc_o !== 32'h340) begin n_fail++; $display("FAIL post_reset_target got=%0h exp=340", bus.redirect_pc_o); end
    n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL post_reset_branch_cnt got=%0h exp=%0h", bus.branch_cnt_o, exp_branch); end
    tick(); tick();
    n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_flush_end got=%0h exp=0", bus.flush_o); end
  endtask

  task automatic test_funct3_unused();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, (k == 0) ? 3'b010 : 3'b011, 32'hA00, 32'h20, 32'h0, 32'h5, 32'h5);
      tick(); idle();
      exp_branch++;
      n_checks++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL f3_%0d_redirect got=%0h exp=0", k, bus.redirect_o); end
      n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL f3_%0d_flush got=%0h exp=0", k, bus.flush_o); end
      n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL f3_%0d_branch_cnt got=%0h exp=%0h", k, bus.branch_cnt_o, exp_branch); end
      n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL f3_%0d_taken_cnt got=%0h exp=%0h", k, bus.taken_cnt_o, exp_taken); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      bit br, jal, jalr, st, c, tk, acc, exp_red, exp_mis, first, s;
      logic [2:0] f3;
      logic [31:0] pc, imm, rs1, a, b, tgt;
      int remaining, nstall;
      br   = ($urandom_range(0, 3) != 0);
      jal  = ($urandom_range(0, 5) == 0);
      jalr = ($urandom_range(0, 5) == 0);
      f3   = 3'($urandom_range(0, 7));
      pc   = $urandom & 32'hFFFF_FFFC;
      imm  = $urandom;
      if (!jalr) imm[0] = 1'b0;
      rs1  = $urandom;
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      st   = ($urandom_range(0, 7) == 0);
      case (f3)
        3'b000:  c = (a == b);
        3'b001:  c = (a != b);
        3'b100:  c = ($signed(a) <  $signed(b));
        3'b101:  c = ($signed(a) >= $signed(b));
        3'b110:  c = (a <  b);
        3'b111:  c = (a >= b);
        default: c = 1'b0;
      endcase
      tk  = jal | jalr | (br & c);
      tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      acc = !st;
      drive(br, jal, jalr, f3, pc, imm, rs1, a, b);
      bus.stall_i = st;
      tick(); idle();
      if (acc && br) exp_branch++;
      if (acc && tk) exp_taken++;
      exp_red = acc && tk && !tgt[1];
      exp_mis = acc && tk && tgt[1];
      if (exp_red) last_rpc = tgt;
      if (exp_mis) last_bad = tgt;
      n_checks++; if (bus.redirect_o !== exp_red) begin n_fail++; $display("FAIL rnd%0d_redirect got=%0h exp=%0h", it, bus.redirect_o, exp_red); end
      n_checks++; if (bus.misaligned_o !== exp_mis) begin n_fail++; $display("FAIL rnd%0d_misaligned got=%0h exp=%0h", it, bus.misaligned_o, exp_mis); end
      n_checks++; if (bus.redirect_pc_o !== last_rpc) begin n_fail++; $display("FAIL rnd%0d_redirect_pc got=%0h exp=%0h", it, bus.redirect_pc_o, last_rpc); end
      n_checks++; if (bus.bad_pc_o !== last_bad) begin n_fail++; $display("FAIL rnd%0d_bad_pc got=%0h exp=%0h", it, bus.bad_pc_o, last_bad); end
      n_checks++; if (bus.branch_cnt_o !== exp_branch) begin n_fail++; $display("FAIL rnd%0d_branch_cnt got=%0h exp=%0h", it, bus.branch_cnt_o, exp_branch); end
      n_checks++; if (bus.taken_cnt_o !== exp_taken) begin n_fail++; $display("FAIL rnd%0d_taken_cnt got=%0h exp=%0h", it, bus.taken_cnt_o, exp_taken); end
      n_checks++; if (bus.flush_o !== exp_red) begin n_fail++; $display("FAIL rnd%0d_flush_start got=%0h exp=%0h", it, bus.flush_o, exp_red); end
      if (exp_red) begin
        remaining = FC; nstall = 0; first = 1;
        while (remaining > 0) begin
          n_checks++; if (bus.flush_o !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_flush_hold got=%0h exp=1", it, bus.flush_o); end
          n_checks++; if (bus.redirect_o !== first) begin n_fail++; $display("FAIL rnd%0d_redirect_len got=%0h exp=%0h", it, bus.redirect_o, first); end
          s = (nstall < 4) && ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 1) == 1)
            drive(1, 1, 0, 3'b000, $urandom & 32'hFFFF_FFFC, 32'h10, 32'h0, 32'h1, 32'h1);
          bus.stall_i = s;
          if (!s) remaining--;
          nstall += s;
          first = 0;
          tick(); idle();
        end
        n_checks++; if (bus.flush_o !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_flush_end got=%0h exp=0", it, bus.flush_o); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_cond_mix();
    test_jumps();
    test_stall_flush();
    test_async_reset();
    test_funct3_unused();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
